// File: rtl/seq_add.sv
// seq_add: sequential adder that sums CHUNK bits of the operands per clock.
// Define SEQ_ADD_SUB_EN to add the sub port (result becomes x + ~y + z when sub=1).
module seq_add #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             z,
`ifdef SEQ_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             carry_q, carry_d;
    logic             c_q, c_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [CHUNK:0]   chunk_sum_s;
    logic [WIDTH-1:0] y_eff_s;
    logic             accept_s;
    logic             last_s;
    int               lo_s;

    // Operand B as seen by the adder; subtraction adds the one's complement of y.
    always_comb begin
`ifdef SEQ_ADD_SUB_EN
        y_eff_s = sub ? ~y : y;
`else
        y_eff_s = y;
`endif
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only honoured outside RUN.
    always_comb begin
        accept_s = start && ((state_q == IDLE) || (state_q == DONE));
        last_s   = (cnt_q == CW'(N - 1));
        case (state_q)
            IDLE:    state_d = start ? RUN : IDLE;
            RUN:     state_d = last_s ? DONE : RUN;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: capture on accept, one chunk per RUN cycle, publish on the last chunk.
    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        part_d      = part_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        s_d         = s_q;
        c_d         = c_q;
        ovf_d       = ovf_q;
        lo_s        = int'(cnt_q) * CHUNK;
        chunk_sum_s = {1'b0, a_q[lo_s +: CHUNK]} + {1'b0, b_q[lo_s +: CHUNK]}
                    + {{CHUNK{1'b0}}, carry_q};
        if (accept_s) begin
            a_d     = x;
            b_d     = y_eff_s;
            carry_d = z;
            cnt_d   = '0;
            part_d  = '0;
        end else if (state_q == RUN) begin
            part_d[lo_s +: CHUNK] = chunk_sum_s[CHUNK-1:0];
            carry_d               = chunk_sum_s[CHUNK];
            if (last_s) begin
                cnt_d = '0;
                s_d   = part_d;
                c_d   = chunk_sum_s[CHUNK];
                // a^b^sum at the MSB recovers the carry into the MSB.
                ovf_d = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ part_d[WIDTH-1] ^ chunk_sum_s[CHUNK];
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Datapath and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            part_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            part_q  <= part_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            c_q     <= c_d;
            ovf_q   <= ovf_d;
        end
    end

    // Outputs decoded from the state register.
    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
        s    = s_q;
        c    = c_q;
        ovf  = ovf_q;
    end

endmodule

// File: tb/tb_seq_add.sv
// tb_seq_add: directed self-checking bench for seq_add (16/4, 16/16 and 1/1 builds).
`timescale 1ns/1ps
module tb_seq_add;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic        start_a, z_a, c_a, ovf_a, busy_a, done_a;
    logic [15:0] x_a, y_a, s_a;
    logic        start_b, z_b, c_b, ovf_b, busy_b, done_b;
    logic [15:0] x_b, y_b, s_b;
    logic        start_c, z_c, c_c, ovf_c, busy_c, done_c;
    logic [0:0]  x_c, y_c, s_c;
`ifdef SEQ_ADD_SUB_EN
    logic        sub_a, sub_b, sub_c;
`endif

    seq_add #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .start(start_a), .x(x_a), .y(y_a), .z(z_a),
`ifdef SEQ_ADD_SUB_EN
        .sub(sub_a),
`endif
        .s(s_a), .c(c_a), .ovf(ovf_a), .busy(busy_a), .done(done_a)
    );

    seq_add #(.WIDTH(16), .CHUNK(16)) dut_wide (
        .clk(clk), .rst(rst), .start(start_b), .x(x_b), .y(y_b), .z(z_b),
`ifdef SEQ_ADD_SUB_EN
        .sub(sub_b),
`endif
        .s(s_b), .c(c_b), .ovf(ovf_b), .busy(busy_b), .done(done_b)
    );

    seq_add #(.WIDTH(1), .CHUNK(1)) dut_bit (
        .clk(clk), .rst(rst), .start(start_c), .x(x_c), .y(y_c), .z(z_c),
`ifdef SEQ_ADD_SUB_EN
        .sub(sub_c),
`endif
        .s(s_c), .c(c_c), .ovf(ovf_c), .busy(busy_c), .done(done_c)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue_a(input logic [15:0] xv, input logic [15:0] yv, input logic zv);
        start_a = 1'b1;
        x_a     = xv;
        y_a     = yv;
        z_a     = zv;
    endtask

    // Called at the negedge where start_a is high; returns at the negedge showing done.
    task automatic wait_done_a(input string tag, input logic [15:0] prev_s, input int restart_at);
        int cyc;
        bit seen;
        @(negedge clk);
        start_a = 1'b0;
        x_a     = 16'hDEAD;
        y_a     = 16'hBEEF;
        z_a     = ~z_a;
        check_eq({tag, "_busy"}, {31'd0, busy_a}, 32'd1);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            start_a = (cyc == restart_at);
            if (cyc == restart_at) begin
                x_a = 16'h1111;
                y_a = 16'h2222;
            end
            if (done_a) seen = 1'b1;
            else check_eq({tag, "_hold"}, {16'd0, s_a}, {16'd0, prev_s});
        end
        start_a = 1'b0;
        check_eq({tag, "_latency"}, cyc, 32'd4);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int done_cnt;
        rst = 1'b1;
        start_a = 1'b0; x_a = 16'h0; y_a = 16'h0; z_a = 1'b0;
        start_b = 1'b0; x_b = 16'h0; y_b = 16'h0; z_b = 1'b0;
        start_c = 1'b0; x_c = 1'b0;  y_c = 1'b0;  z_c = 1'b0;
`ifdef SEQ_ADD_SUB_EN
        sub_a = 1'b0; sub_b = 1'b0; sub_c = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check_eq("rst_s",    {16'd0, s_a},     32'd0);
        check_eq("rst_c",    {31'd0, c_a},     32'd0);
        check_eq("rst_ovf",  {31'd0, ovf_a},   32'd0);
        check_eq("rst_busy", {31'd0, busy_a},  32'd0);
        check_eq("rst_done", {31'd0, done_a},  32'd0);
        rst = 1'b0;
        @(negedge clk);

        // FFFF + 1: wrap to zero with carry-out, no signed overflow.
        issue_a(16'hFFFF, 16'h0001, 1'b0);
        wait_done_a("r34", 16'h0000, -1);
        check_eq("r34_s",   {16'd0, s_a},   32'h0000);
        check_eq("r34_c",   {31'd0, c_a},   32'd1);
        check_eq("r34_ovf", {31'd0, ovf_a}, 32'd0);
        @(negedge clk);
        check_eq("r34_done_pulse", {31'd0, done_a}, 32'd0);
        check_eq("r34_idle",       {31'd0, busy_a}, 32'd0);

        // 7FFF + 1 overflows; the next op is issued in the DONE cycle.
        issue_a(16'h7FFF, 16'h0001, 1'b0);
        wait_done_a("r35a", 16'h0000, -1);
        check_eq("r35a_s",   {16'd0, s_a},   32'h8000);
        check_eq("r35a_c",   {31'd0, c_a},   32'd0);
        check_eq("r35a_ovf", {31'd0, ovf_a}, 32'd1);
        issue_a(16'h1234, 16'h4321, 1'b1);
        wait_done_a("r35b", 16'h8000, -1);
        check_eq("r35b_s",   {16'd0, s_a},   32'h5556);
        check_eq("r35b_c",   {31'd0, c_a},   32'd0);
        check_eq("r35b_ovf", {31'd0, ovf_a}, 32'd0);
        @(negedge clk);

        // start re-pulsed during RUN must be ignored.
        issue_a(16'h0F0F, 16'h00F1, 1'b0);
        wait_done_a("r36", 16'h5556, 2);
        check_eq("r36_s", {16'd0, s_a}, 32'h1000);
        check_eq("r36_c", {31'd0, c_a}, 32'd0);
        done_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (done_a) done_cnt++;
        end
        check_eq("r36_single_done", done_cnt, 32'd0);
        check_eq("r36_s_held",      {16'd0, s_a}, 32'h1000);

        // Asynchronous reset while chunk 2 is in flight.
        issue_a(16'h00FF, 16'h0101, 1'b0);
        @(negedge clk);
        start_a = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("r37_s",    {16'd0, s_a},    32'd0);
        check_eq("r37_c",    {31'd0, c_a},    32'd0);
        check_eq("r37_ovf",  {31'd0, ovf_a},  32'd0);
        check_eq("r37_busy", {31'd0, busy_a}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (done_a) done_cnt++;
        end
        check_eq("r37_no_done", done_cnt, 32'd0);
        issue_a(16'h00FF, 16'h0101, 1'b0);
        wait_done_a("r37b", 16'h0000, -1);
        check_eq("r37b_s", {16'd0, s_a}, 32'h0200);
        check_eq("r37b_c", {31'd0, c_a}, 32'd0);

`ifdef SEQ_ADD_SUB_EN
        // 5 - 7 = -2, borrow shown as c=0.
        @(negedge clk);
        sub_a = 1'b1;
        issue_a(16'h0005, 16'h0007, 1'b1);
        wait_done_a("sub", 16'h0200, -1);
        sub_a = 1'b0;
        check_eq("sub_s",   {16'd0, s_a},   32'hFFFE);
        check_eq("sub_c",   {31'd0, c_a},   32'd0);
        check_eq("sub_ovf", {31'd0, ovf_a}, 32'd0);
`endif

        // CHUNK == WIDTH: result one cycle after acceptance.
        @(negedge clk);
        start_b = 1'b1; x_b = 16'h00FF; y_b = 16'h0001; z_b = 1'b0;
        @(negedge clk);
        start_b = 1'b0; x_b = 16'hFFFF; y_b = 16'hFFFF;
        check_eq("wide_busy", {31'd0, busy_b}, 32'd1);
        check_eq("wide_early_done", {31'd0, done_b}, 32'd0);
        @(negedge clk);
        check_eq("wide_done", {31'd0, done_b}, 32'd1);
        check_eq("wide_s",    {16'd0, s_b},    32'h0100);
        check_eq("wide_c",    {31'd0, c_b},    32'd0);

        // WIDTH == 1: ovf is carry-in XOR carry-out.
        start_c = 1'b1; x_c = 1'b1; y_c = 1'b0; z_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0; x_c = 1'b0; z_c = 1'b0;
        @(negedge clk);
        check_eq("bit1_done", {31'd0, done_c}, 32'd1);
        check_eq("bit1_s",    {31'd0, s_c},    32'd0);
        check_eq("bit1_c",    {31'd0, c_c},    32'd1);
        check_eq("bit1_ovf",  {31'd0, ovf_c},  32'd0);
        start_c = 1'b1; x_c = 1'b0; y_c = 1'b0; z_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0; z_c = 1'b0;
        @(negedge clk);
        check_eq("bit2_done", {31'd0, done_c}, 32'd1);
        check_eq("bit2_s",    {31'd0, s_c},    32'd1);
        check_eq("bit2_c",    {31'd0, c_c},    32'd0);
        check_eq("bit2_ovf",  {31'd0, ovf_c},  32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_add.md
SEQ_ADD -- requirements
Module: seq_add

Interface
REQ-001 Parameter WIDTH, default 16, operand and sum width in bits.
REQ-002 Parameter CHUNK, default 4, bits added per clock; WIDTH SHALL be an integer multiple of CHUNK; N = WIDTH/CHUNK.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  request an add; sampled on rising clk.
REQ-006 x  in  WIDTH  operand A, captured at accepted start.
REQ-007 y  in  WIDTH  operand B, captured at accepted start.
REQ-008 z  in  1  carry-in, captured at accepted start.
REQ-009 s  out  WIDTH  registered sum.
REQ-010 c  out  1  registered carry-out of MSB.
REQ-011 ovf  out  1  registered two's-complement overflow (carry into MSB XOR carry out of MSB).
REQ-012 busy  out  1  high while an operation is in progress.
REQ-013 done  out  1  one-cycle pulse marking a new valid s/c/ovf.
REQ-014 sub  in  1  subtract select; present only when SEQ_ADD_SUB_EN is defined (REQ-032).

Function
REQ-015 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-016 IDLE or DONE with start=1: capture x, y, z into internal registers, clear chunk counter, go RUN.
REQ-017 RUN: each cycle add chunk k (bits k*CHUNK+CHUNK-1..k*CHUNK) of captured operands plus running carry, store partial sum, update running carry, k+1.
REQ-018 RUN after chunk N-1: load s, c, ovf from final result in the same edge, go DONE.
REQ-019 DONE lasts exactly one cycle; done=1 only in DONE; next state IDLE, or RUN if start=1.
REQ-020 Latency: start accepted at edge E0 -> s/c/ovf updated and done=1 after edge EN; N cycles busy; back-to-back throughput one result per N+1 cycles.
REQ-021 busy=1 exactly in RUN; start while busy ignored, captured operands unaffected.
REQ-022 s, c, ovf change only at the completion edge; hold previous result otherwise, including during a following RUN.
REQ-023 Changes on x, y, z after the accepting edge SHALL not affect the result.
REQ-024 Arithmetic modulo 2^WIDTH; c = bit WIDTH of x+y+z.
REQ-025 CHUNK=WIDTH: N=1, single RUN cycle, result after E1.
REQ-026 WIDTH=1 legal with CHUNK=1; ovf = carry-in to bit 0 XOR c.

Reset
REQ-027 rst=1 forces IDLE immediately, regardless of clk.
REQ-028 Reset values: s=0, c=0, ovf=0, busy=0, done=0; counter and captured operands cleared.
REQ-029 rst during RUN aborts the operation; no done pulse for it; no partial result reaches s.
REQ-030 First start after rst deasserts is accepted normally.

Configuration
REQ-031 Macro SEQ_ADD_SUB_EN selects subtract support.
REQ-032 Defined: port sub exists, captured at accepted start; sub=1 computes x - y - (~z & 1)... specifically x + ~y + z, caller drives z=1 for plain x-y; c=1 means no borrow; ovf per signed subtract.
REQ-033 Undefined: no sub port; block is add-only; all other behaviour identical.

Verification (WIDTH=16, CHUNK=4 unless stated)
REQ-034 x=0xFFFF, y=0x0001, z=0, start -> after 4 cycles done=1, s=0x0000, c=1, ovf=0.
REQ-035 x=0x7FFF, y=0x0001, z=0 -> s=0x8000, c=0, ovf=1; then x=0x1234, y=0x4321, z=1 issued in DONE cycle -> s=0x5556, c=0, no idle gap.
REQ-036 start pulsed again 2 cycles into RUN with different x/y -> ignored; single done, first result only.
REQ-037 rst asserted mid-cycle in RUN chunk 2 -> outputs 0 asynchronously, no done; next start yields correct sum.
REQ-038 SEQ_ADD_SUB_EN defined, sub=1, x=0x0005, y=0x0007, z=1 -> s=0xFFFE, c=0; CHUNK=16 build: 0x00FF+0x0001 -> s=0x0100, done one cycle after start.
